// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor:
// mode encoding, slice-width helper and saturation bounds.
package pipe_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Widest operand the saturation helpers can describe.
  localparam int SAT_MAX_N = 64;

  function automatic int slice_width(input int n, input int stages);
    return n / stages;
  endfunction

  // Largest positive two's-complement value of an n-bit word (0x7FF..F).
  function automatic logic [SAT_MAX_N-1:0] sat_max(input int n);
    logic [SAT_MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < n - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Most negative two's-complement value of an n-bit word (0x800..0).
  function automatic logic [SAT_MAX_N-1:0] sat_min(input int n);
    logic [SAT_MAX_N-1:0] r;
    r = '0;
    r[n-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple slice built from full_adder cells.
// Besides the slice carry-out it exposes the carry into its MSB so
// the top slice can form the signed-overflow flag.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of every slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined N-bit adder/subtractor split into STAGES equal slices,
// each slice followed by one register level.
// Optional feature macro: PIPE_ADDSUB_SAT_EN (clamp Sum on signed overflow).
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready are both high. in_ready is high whenever the pipe can
// shift (output empty or being taken); while out_valid && !out_ready the
// whole pipe freezes and Sum/Cout/V hold. Bubbles are never collapsed.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         V,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int W = slice_width(N, STAGES);

  if (STAGES < 1 || STAGES > N) begin : g_bad_stages
    $error("pipe_addsub: STAGES must be within 1..N");
  end
  if (N % STAGES != 0) begin : g_bad_split
    $error("pipe_addsub: N must be a multiple of STAGES");
  end

  logic advance;

  // Per-stage registers. Stage k holds the transaction after slice k:
  // its full operand words (upper slices still to be added), the sum
  // bits produced so far, and the carry handed to slice k+1.
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] c_r;
  logic [N-1:0]      a_r   [STAGES];
  logic [N-1:0]      b_r   [STAGES];
  logic [N-1:0]      sum_r [STAGES];
  logic              v_r;

  // Combinational view of what each slice sees and produces.
  logic [N-1:0]      a_in    [STAGES];
  logic [N-1:0]      b_in    [STAGES];
  logic [STAGES-1:0] c_in;
  logic [W-1:0]      sl_s    [STAGES];
  logic [STAGES-1:0] sl_co;
  logic [STAGES-1:0] sl_cm;
  logic [N-1:0]      sum_nxt [STAGES];

  logic         v_nxt;
  logic [N-1:0] last_sum;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0] base;
    logic [N-1:0] nxt;

    if (k == 0) begin : g_first
      // Subtract is folded in at entry: A + ~B + ~Cin == A - B - Cin.
      assign a_in[0] = A;
      assign b_in[0] = (Sub == MODE_SUB) ? ~B : B;
      assign c_in[0] = (Sub == MODE_SUB) ? ~Cin : Cin;
      assign base    = '0;
    end else begin : g_rest
      assign a_in[k] = a_r[k-1];
      assign b_in[k] = b_r[k-1];
      assign c_in[k] = c_r[k-1];
      assign base    = sum_r[k-1];
    end

    adder_slice #(.W(W)) u_slice (
      .a    (a_in[k][k*W +: W]),
      .b    (b_in[k][k*W +: W]),
      .cin  (c_in[k]),
      .s    (sl_s[k]),
      .cout (sl_co[k]),
      .cmsb (sl_cm[k])
    );

    // Merge this slice's result into the partial sum carried forward.
    always_comb begin
      nxt = base;
      nxt[k*W +: W] = sl_s[k];
    end

    assign sum_nxt[k] = nxt;
  end

  // Signed overflow: carry into bit N-1 differs from carry out of it.
  assign v_nxt = sl_cm[STAGES-1] ^ sl_co[STAGES-1];

`ifdef PIPE_ADDSUB_SAT_EN
  if (N > SAT_MAX_N) begin : g_bad_sat_width
    $error("pipe_addsub: saturation supports N up to SAT_MAX_N");
  end

  localparam logic [SAT_MAX_N-1:0] SAT_MAX_FULL = sat_max(N);
  localparam logic [SAT_MAX_N-1:0] SAT_MIN_FULL = sat_min(N);
  localparam logic [N-1:0]         SAT_MAX_VAL  = SAT_MAX_FULL[N-1:0];
  localparam logic [N-1:0]         SAT_MIN_VAL  = SAT_MIN_FULL[N-1:0];

  // Clamp on overflow: a wrapped MSB of 1 means positive overflow.
  always_comb begin
    last_sum = sum_nxt[STAGES-1];
    if (v_nxt) begin
      last_sum = sum_nxt[STAGES-1][N-1] ? SAT_MAX_VAL : SAT_MIN_VAL;
    end
  end
`else
  assign last_sum = sum_nxt[STAGES-1];
`endif

  // Pipeline registers: all stages shift together on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= '0;
      c_r   <= '0;
      v_r   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        sum_r[k] <= '0;
      end
    end else if (advance) begin
      vld_r[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_r[k] <= vld_r[k-1];
      c_r <= sl_co;
      v_r <= v_nxt;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= a_in[k];
        b_r[k] <= b_in[k];
        if (k == STAGES - 1) sum_r[k] <= last_sum;
        else                 sum_r[k] <= sum_nxt[k];
      end
    end
  end

  assign Sum       = sum_r[STAGES-1];
  assign Cout      = c_r[STAGES-1];
  assign V         = v_r;
  assign out_valid = vld_r[STAGES-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub (N=16, STAGES=4): corner-case vectors,
// a random add/sub stream, backpressure and mid-flight reset.
module tb_pipe_addsub;

  localparam int N      = 16;
  localparam int STAGES = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         V;
  logic         out_valid;
  logic         out_ready;

  int tests = 0;
  int fails = 0;

  logic [17:0] exp_q[$];

`ifdef PIPE_ADDSUB_SAT_EN
  localparam logic [15:0] POS_OVF_SUM = 16'h7FFF;
  localparam logic [15:0] NEG_OVF_SUM = 16'h8000;
`else
  localparam logic [15:0] POS_OVF_SUM = 16'h8000;
  localparam logic [15:0] NEG_OVF_SUM = 16'h7FFF;
`endif

  pipe_addsub #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .V         (V),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {Cout, V, Sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] full;
    logic [15:0] low;
    logic        v;
    logic [15:0] s;
    bb   = sub ? ~b : b;
    c0   = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, bb} + {16'b0, c0};
    low  = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + {15'b0, c0};
    v    = low[15] ^ full[16];
    s    = full[15:0];
`ifdef PIPE_ADDSUB_SAT_EN
    if (v) s = s[15] ? 16'h7FFF : 16'h8000;
`endif
    return {full[16], v, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one transaction into an empty pipe, then check latency and result.
  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] es, input logic ec, input logic ev);
    int edges;
    A = a; B = b; Cin = cin; Sub = sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    check({tag, "_latency"}, edges, STAGES);
    check({tag, "_sum"}, Sum, es);
    check({tag, "_cout"}, Cout, ec);
    check({tag, "_v"}, V, ev);
    step();
    check({tag, "_valid_one_cycle"}, out_valid, 0);
  endtask

  // Driver + scoreboard: n random transactions, optional output stall window.
  task automatic run_stream(input string tag, input int n, input int stall_at,
                            input int stall_len);
    logic [15:0] ta [32];
    logic [15:0] tb [32];
    logic        tc [32];
    logic        ts [32];
    logic [17:0] e;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int first = -1;
    int last  = -1;
    for (int i = 0; i < n; i++) begin
      ta[i] = 16'($urandom_range(0, 65535));
      tb[i] = 16'($urandom_range(0, 65535));
      tc[i] = 1'($urandom_range(0, 1));
      ts[i] = 1'($urandom_range(0, 1));
    end
    while (got < n && cyc < 300) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (idx < n);
      if (idx < n) begin
        A = ta[idx]; B = tb[idx]; Cin = tc[idx]; Sub = ts[idx];
      end
      #1;
      if (!out_ready) begin
        check({tag, "_stall_in_ready"}, in_ready, 0);
        check({tag, "_stall_valid"}, out_valid, 1);
        if (exp_q.size() > 0) check({tag, "_stall_hold"}, {Cout, V, Sum}, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_out"}, out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_result"}, {Cout, V, Sum}, e);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ta[idx], tb[idx], tc[idx], ts[idx]));
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, got, n);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_span"}, last - first, n - 1 + stall_len);
  endtask

  initial begin
    int seen;
    rst = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", Sum, 0);
    check("reset_cout", Cout, 0);
    check("reset_v", V, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    step();

    // Directed vectors
    send_one("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    send_one("add_carry_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("add_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, POS_OVF_SUM, 1'b0, 1'b1);
    send_one("sub_basic", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("sub_neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, NEG_OVF_SUM, 1'b1, 1'b1);
    send_one("sub_borrow_in", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // Streaming and backpressure
    run_stream("stream", 20, 1000, 0);
    run_stream("bp", 12, 8, 6);

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      A = 16'h1111 * 16'(i + 1); B = 16'h0101; Cin = 1'b0; Sub = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", Sum, 0);
    check("midrst_cout", Cout, 0);
    check("midrst_v", V, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("midrst_no_stale", seen, 0);
    send_one("after_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
